// File: rtl/avalon_sample_writer_if.sv
// Avalon-MM write-only bus between the sample writer (master) and system memory (slave).
`timescale 1ns/1ps
interface avalon_sample_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   address;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;

    modport master (
        output address,
        output write,
        output writedata,
        output byteenable,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  byteenable,
        output waitrequest
    );
endinterface

// File: rtl/avalon_sample_writer.sv
// Drains DEPTH samples from a synchronous sample RAM into memory as Avalon-MM writes,
// one beat per sample at incrementing byte addresses, with a waitrequest timeout.
`timescale 1ns/1ps
module avalon_sample_writer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic [IDX_W-1:0]      sample_addr,
    input  logic [DATA_W-1:0]     sample_data,
    avalon_sample_writer_if.master avm,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, DONE, ERR} state_t;

    state_t            state, next_state;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] base;
    logic [TO_W-1:0]   wait_cnt;
    logic              accepted;
    logic              timed_out;

    assign accepted  = (state == WRITE) && !avm.waitrequest;
    assign timed_out = (state == WRITE) && avm.waitrequest && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, ERR: if (start) next_state = FETCH;
            FETCH: begin
                busy       = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                next_state = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (accepted)       next_state = (idx == LAST_IDX) ? DONE : FETCH;
                else if (timed_out) next_state = ERR;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The beat registers are loaded once in LOAD and left alone for the whole WRITE stall.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            idx           <= '0;
            base          <= '0;
            sample_addr   <= '0;
            wait_cnt      <= '0;
            error         <= 1'b0;
            avm.address   <= '0;
            avm.writedata <= '0;
            avm.write     <= 1'b0;
        end else begin
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        base        <= base_addr;
                        idx         <= '0;
                        sample_addr <= '0;
                        wait_cnt    <= '0;
                        error       <= 1'b0;
                    end
                end
                LOAD: begin
                    avm.writedata <= sample_data;
                    avm.address   <= base + ADDR_W'(idx) * STRIDE;
                    avm.write     <= 1'b1;
                end
                WRITE: begin
                    if (accepted) begin
                        avm.write <= 1'b0;
                        wait_cnt  <= '0;
                        if (idx != LAST_IDX) begin
                            idx         <= idx + 1'b1;
                            sample_addr <= idx + 1'b1;
                        end
                    end else if (timed_out) begin
                        avm.write <= 1'b0;
                        wait_cnt  <= '0;
                        error     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign avm.byteenable = avm.write ? '1 : '0;
endmodule

// File: tb/tb_avalon_sample_writer.sv
// Randomized bench for avalon_sample_writer: a negedge monitor checks every accepted beat
// against an address/data list derived from base + 2*n and the RAM contents.
`timescale 1ns/1ps
module tb_avalon_sample_writer;
    localparam int DEPTH   = 512;
    localparam int SMALL   = 4;
    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] base_addr2 = '0;
    logic [8:0]  sample_addr;
    logic [1:0]  sample_addr2;
    logic [15:0] sample_data;
    logic [15:0] sample_data2;
    logic        busy, done, error;
    logic        busy2, done2, error2;
    logic [15:0] ram [DEPTH];
    logic [15:0] ram2 [SMALL];

    avalon_sample_writer_if #(.ADDR_W(32), .DATA_W(16)) bus ();
    avalon_sample_writer_if #(.ADDR_W(32), .DATA_W(16)) bus2 ();

    always #5 clk = ~clk;

    avalon_sample_writer dut (
        .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
        .sample_addr(sample_addr), .sample_data(sample_data), .avm(bus.master),
        .busy(busy), .done(done), .error(error)
    );

    avalon_sample_writer #(.DEPTH(SMALL)) dut2 (
        .clk(clk), .n_rst(n_rst), .start(start2), .base_addr(base_addr2),
        .sample_addr(sample_addr2), .sample_data(sample_data2), .avm(bus2.master),
        .busy(busy2), .done(done2), .error(error2)
    );

    always @(posedge clk) sample_data  <= ram[sample_addr];
    always @(posedge clk) sample_data2 <= ram2[sample_addr2];

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference state: beats accepted so far in the current run and the run's base.
    int          mode = 0;
    int          stall_beat = 0;
    int          beats = 0;
    int          done_count = 0;
    int          rel_cyc = 0;
    int          done_cyc = 0;
    int          last_acc_cyc = -10;
    int          stall_run = 0;
    int          last_stall_run = 0;
    logic [31:0] run_base = '0;
    bit          prev_stall = 1'b0;
    bit          mon_w;
    logic [31:0] prev_addr;
    logic [15:0] prev_data;

    // Each negedge decides the waitrequest seen by the next posedge, so a beat is
    // accepted exactly when write is high here and the chosen waitrequest is low.
    always @(negedge clk) begin
        rel_cyc++;
        if (n_rst) begin
            prev_stall      = 1'b0;
            stall_run       = 0;
            bus.waitrequest = 1'b0;
        end else begin
            mon_w = (mode == 1) ? ($urandom_range(0, 1) == 1) : (mode == 2 && beats == stall_beat);
            checkOutput("byteenable", 64'(bus.byteenable), bus.write ? 64'h3 : 64'h0);
            if (prev_stall && bus.write) begin
                checkOutput("hold_addr", 64'(bus.address), 64'(prev_addr));
                checkOutput("hold_data", 64'(bus.writedata), 64'(prev_data));
            end
            if (bus.write) begin
                if (mon_w) begin
                    stall_run++;
                end else begin
                    if (beats < DEPTH) begin
                        checkOutput("beat_addr", 64'(bus.address), 64'(run_base + 32'(2 * beats)));
                        checkOutput("beat_data", 64'(bus.writedata), 64'(ram[beats]));
                    end else begin
                        checkOutput("extra_beat", 64'(beats), 64'(DEPTH - 1));
                    end
                    beats++;
                    last_acc_cyc = rel_cyc;
                    stall_run    = 0;
                end
            end else if (prev_stall) begin
                last_stall_run = stall_run;
                stall_run      = 0;
            end
            prev_stall = bus.write && mon_w;
            prev_addr  = bus.address;
            prev_data  = bus.writedata;
            if (done) begin
                done_count++;
                done_cyc = rel_cyc;
                checkOutput("done_after_last", 64'(rel_cyc - last_acc_cyc), 64'd1);
                checkOutput("done_beats", 64'(beats), 64'(DEPTH));
            end
            bus.waitrequest = mon_w;
        end
    end

    logic [31:0] q2_addr [$];
    logic [15:0] q2_data [$];
    int          done2_count = 0;

    always @(negedge clk) begin
        if (!n_rst) begin
            if (bus2.write) begin
                q2_addr.push_back(bus2.address);
                q2_data.push_back(bus2.writedata);
            end
            if (done2) done2_count++;
        end
    end

    task automatic applyStimulus(input logic [31:0] base, input int m, input int sb);
        @(posedge clk);
        #2;
        mode           = m;
        stall_beat     = sb;
        beats          = 0;
        done_count     = 0;
        rel_cyc        = -1;
        last_acc_cyc   = -10;
        last_stall_run = 0;
        run_base       = base;
        base_addr      = base;
        start          = 1'b1;
        @(posedge clk);
        #2;
        start     = 1'b0;
        base_addr = ~base;
    endtask

    task automatic waitFinish(input int budget, input bit poke_done);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_count > 0 || error) break;
        end
        checkOutput("finish_in_budget", 64'(done_count > 0 || error), 64'd1);
        if (poke_done && done_count > 0) begin
            start = 1'b1;
            @(negedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic checkIdleAfter(input string tag);
        repeat (8) @(negedge clk);
        #1;
        checkOutput({tag, "_done_count"}, 64'(done_count), 64'd1);
        checkOutput({tag, "_beats"}, 64'(beats), 64'(DEPTH));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_write"}, 64'(bus.write), 64'd0);
    endtask

    initial begin
        logic [31:0] exp2 [SMALL];
        exp2 = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0002};
        bus2.waitrequest = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 16'(i);
        for (int i = 0; i < SMALL; i++) ram2[i] = 16'($urandom);

        #12;
        checkOutput("rst_write", 64'(bus.write), 64'd0);
        checkOutput("rst_address", 64'(bus.address), 64'd0);
        checkOutput("rst_writedata", 64'(bus.writedata), 64'd0);
        checkOutput("rst_byteenable", 64'(bus.byteenable), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        checkOutput("rst_sample_addr", 64'(sample_addr), 64'd0);
        #11;
        n_rst = 1'b0;

        $display("[TB] full-rate transfer");
        applyStimulus(32'h1000_0000, 0, 0);
        waitFinish(2000, 1'b0);
        checkOutput("full_done_cycle", 64'(done_cyc), 64'(3 * DEPTH + 1));
        checkIdleAfter("full");

        $display("[TB] random waitrequest");
        for (int i = 0; i < DEPTH; i++) ram[i] = 16'($urandom);
        applyStimulus($urandom, 1, 0);
        waitFinish(8000, 1'b0);
        checkIdleAfter("rand");

        $display("[TB] timeout on beat 5");
        applyStimulus(32'h2000_0000, 2, 5);
        waitFinish(3000, 1'b0);
        checkOutput("to_error", 64'(error), 64'd1);
        checkOutput("to_stalls", 64'(last_stall_run), 64'(TIMEOUT));
        checkOutput("to_write", 64'(bus.write), 64'd0);
        checkOutput("to_busy", 64'(busy), 64'd0);
        checkOutput("to_beats", 64'(beats), 64'd5);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("to_error_sticky", 64'(error), 64'd1);
        checkOutput("to_no_done", 64'(done_count), 64'd0);
        applyStimulus(32'h3000_0000, 0, 0);
        checkOutput("rerun_error_clear", 64'(error), 64'd0);
        checkOutput("rerun_busy", 64'(busy), 64'd1);
        waitFinish(2000, 1'b0);
        checkOutput("rerun_done_cycle", 64'(done_cyc), 64'(3 * DEPTH + 1));
        checkIdleAfter("rerun");

        $display("[TB] start ignored while busy and in DONE");
        for (int i = 0; i < DEPTH; i++) ram[i] = 16'(i) ^ 16'hA5A5;
        applyStimulus(32'h4000_0000, 1, 0);
        for (int i = 0; i < 3000 && beats < 100; i++) begin
            @(negedge clk);
            #1;
        end
        base_addr = 32'hDEAD_0000;
        start     = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        waitFinish(8000, 1'b1);
        checkIdleAfter("ignore");

        $display("[TB] reset during stalled write");
        applyStimulus(32'h5000_0000, 2, 3);
        for (int i = 0; i < 200 && beats < 3; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (10) @(negedge clk);
        #1;
        checkOutput("stalled_write", 64'(bus.write), 64'd1);
        #2;
        n_rst = 1'b1;
        #1;
        checkOutput("arst_write", 64'(bus.write), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_error", 64'(error), 64'd0);
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        applyStimulus(32'h6000_0000, 0, 0);
        waitFinish(2000, 1'b0);
        checkOutput("post_rst_done_cycle", 64'(done_cyc), 64'(3 * DEPTH + 1));
        checkIdleAfter("post_rst");

        $display("[TB] address wrap with DEPTH=4");
        @(posedge clk);
        #2;
        base_addr2 = 32'hFFFF_FFFC;
        start2     = 1'b1;
        @(posedge clk);
        #2;
        start2 = 1'b0;
        for (int i = 0; i < 50 && done2_count == 0; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("wrap_done", 64'(done2_count), 64'd1);
        checkOutput("wrap_count", 64'(q2_addr.size()), 64'(SMALL));
        for (int i = 0; i < SMALL; i++) begin
            if (i < q2_addr.size()) begin
                checkOutput("wrap_addr", 64'(q2_addr[i]), 64'(exp2[i]));
                checkOutput("wrap_data", 64'(q2_data[i]), 64'(ram2[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/avalon_sample_writer.md
Name: avalon_sample_writer

Overview:
Parametrised Avalon-MM write master that drains a completed FFT result buffer into system memory. A one-cycle start pulse launches the transfer. The block reads DEPTH samples from a synchronous sample RAM and issues one Avalon write per sample at incrementing byte addresses from a programmable base. Successor to the fixed 512x16 writer: adds waitrequest handshaking, a run-time base address, a waitrequest timeout with a sticky error, and done/busy status.

Parameters:
DATA_W, 16, sample and Avalon writedata width in bits; must be a multiple of 8.
ADDR_W, 32, Avalon byte-address width.
DEPTH, 512, samples per transfer; must be at least 2.
IDX_W, $clog2(DEPTH), sample index width.
TIMEOUT, 1023, maximum consecutive waitrequest-high cycles on one beat before error.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous reset, active-high: asserted when 1.
start  in  1  one-cycle launch pulse (fft_done); honoured only in IDLE or ERR.
base_addr  in  ADDR_W  destination byte address; sampled on accepted start.
sample_addr  out  IDX_W  sample RAM read address, registered.
sample_data  in  DATA_W  sample RAM read data; valid 1 cycle after sample_addr.
avm_address  out  ADDR_W  Avalon byte address.
avm_write  out  1  Avalon write request.
avm_writedata  out  DATA_W  Avalon write data.
avm_byteenable  out  DATA_W/8  all ones whenever avm_write=1, else 0.
avm_waitrequest  in  1  slave stall.
busy  out  1  high in FETCH, LOAD and WRITE.
done  out  1  one-cycle pulse after the last beat is accepted.
error  out  1  sticky timeout flag.

Behaviour:
- Reset (n_rst=1, asynchronous): state=IDLE. All outputs 0. idx=0, base register=0, timeout counter=0.
- States: IDLE, FETCH, LOAD, WRITE, DONE, ERR.
- IDLE: when start=1, latch base_addr, set idx=0 and sample_addr=0, clear error, go to FETCH.
- FETCH: RAM sees sample_addr for one cycle, then go to LOAD.
- LOAD: sample_data is valid. Register it into avm_writedata. Set avm_address = base + idx*(DATA_W/8), arithmetic mod 2^ADDR_W (wrap silently). Set avm_write=1 on entry to WRITE. Go to WRITE.
- WRITE: avm_write=1. address, writedata and byteenable stay stable while avm_waitrequest=1.
  - A beat is accepted in the cycle where avm_waitrequest=0.
  - On acceptance: drop avm_write next cycle and clear the timeout counter.
  - If idx==DEPTH-1, go to DONE. Otherwise idx++, sample_addr=idx+1, go to FETCH.
- Timeout: the counter increments each WRITE cycle with waitrequest=1. When it reaches TIMEOUT, drop avm_write, set error=1, go to ERR. The beat is abandoned.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: error stays 1 and busy=0. A start pulse relaunches exactly as from IDLE and clears error.
- start is ignored in FETCH, LOAD, WRITE and DONE; there is no queueing.
- Throughput is at best 3 cycles per sample: FETCH, LOAD, WRITE with waitrequest=0. Minimum transfer is 3*DEPTH cycles from start to the done pulse, plus 1.
- base_addr changes after start have no effect on the current transfer.
- Reset asserted mid-transfer: immediate return to IDLE with avm_write=0. No partial state is retained.

Test Plan:
- Default params, base_addr=0x1000_0000, waitrequest tied 0, RAM[i]=i -> 512 writes at 0x1000_0000+2i with data i. done pulses once, at cycle 1537 after start. busy is low afterwards.
- Random waitrequest (50%) -> same 512 beats in order. Address and data are held stable during every stall. No beat is duplicated or dropped.
- waitrequest held 1 on beat 5 -> after 1023 stall cycles avm_write=0 and error=1, with no done pulse. A new start clears error and the rerun completes all 512 beats.
- base_addr=0xFFFF_FFFC, DEPTH=4 -> addresses 0xFFFF_FFFC, 0xFFFF_FFFE, 0x0000_0000, 0x0000_0002.
- start pulsed during beat 100 and again during DONE -> both ignored. Exactly 512 writes and one done pulse.
- n_rst asserted during a stalled WRITE -> avm_write, busy and error go to 0 asynchronously. A subsequent start transfers from idx 0.
